// File: rtl/rvc_fetch_align.sv
// RVC-aware fetch/realign front end: 32-bit I-cache words into a halfword FIFO, one instruction per cycle to ID.
// Build option: define RVC_EXPAND_EN to expand 16-bit encodings to their RV32I equivalents on out_inst.
module rvc_fetch_align #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        icache_ren,
   output logic [29:0] icache_addr,
   input  logic        icache_stall,
   input  logic [31:0] icache_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic        out_is_rvc
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [15:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
   logic [CW-1:0] count;
   logic          drop_low, pend, pend_drop;
   logic [29:0]   pend_addr;

   logic [15:0]   head, next_hw, lo_hw, hi_hw;
   logic          head_rvc, head_ok, pop, accept;
   logic [1:0]    push_n, pop_n;

`ifdef RVC_EXPAND_EN
   function automatic logic [31:0] expand_rvc(input logic [15:0] c);
      logic [4:0]  rs1p, rs2p, rd;
      logic [31:0] r;
      rs1p = {2'b01, c[9:7]};
      rs2p = {2'b01, c[4:2]};
      rd   = c[11:7];
      r    = {16'h0000, c};
      case ({c[1:0], c[15:13]})
         5'b00_000: r = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rs2p, 7'h13};
         5'b00_010: r = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rs2p, 7'h03};
         5'b00_110: r = {5'b0, c[5], c[12], rs2p, rs1p, 3'b010, c[11:10], c[6], 2'b00, 7'h23};
         5'b01_000: r = {{6{c[12]}}, c[12], c[6:2], rd, 3'b000, rd, 7'h13};
         5'b01_001, 5'b01_101:
            r = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12], {8{c[12]}}, 4'b0000, ~c[15], 7'h6F};
         5'b01_010: r = {{6{c[12]}}, c[12], c[6:2], 5'd0, 3'b000, rd, 7'h13};
         5'b01_011: begin
            if (rd == 5'd2) r = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, 7'h13};
            else            r = {{15{c[12]}}, c[6:2], rd, 7'h37};
         end
         5'b01_100: begin
            case (c[11:10])
               2'b00:   r = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
               2'b01:   r = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
               2'b10:   r = {{6{c[12]}}, c[12], c[6:2], rs1p, 3'b111, rs1p, 7'h13};
               default: r = {1'b0, c[6:5] == 2'b00, 5'b00000, rs2p, rs1p,
                             (c[6:5] == 2'b00) ? 3'b000 : {1'b1, c[6], c[6] & c[5]}, rs1p, 7'h33};
            endcase
         end
         // c.beqz / c.bnez differ only in c[13], which becomes funct3[0]
         5'b01_110, 5'b01_111:
            r = {{4{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 2'b00, c[13], c[11:10], c[4:3], c[12], 7'h63};
         5'b10_000: r = {7'b0, c[6:2], rd, 3'b001, rd, 7'h13};
         5'b10_010: r = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, 7'h03};
         5'b10_100: begin
            if (!c[12])              r = (c[6:2] == 5'd0) ? {12'b0, rd, 3'b000, 5'd0, 7'h67}
                                                         : {7'b0, c[6:2], 5'd0, 3'b000, rd, 7'h33};
            else if (c[6:2] == 5'd0) r = (rd == 5'd0) ? 32'h0010_0073 : {12'b0, rd, 3'b000, 5'd1, 7'h67};
            else                     r = {7'b0, c[6:2], rd, 3'b000, rd, 7'h33};
         end
         5'b10_110: r = {4'b0, c[8:7], c[12], c[6:2], 5'd2, 3'b010, c[11:9], 2'b00, 7'h23};
         default:   r = {16'h0000, c};
      endcase
      return r;
   endfunction
`endif

   assign lo_hw    = {icache_rdata[7:0], icache_rdata[15:8]};
   assign hi_hw    = {icache_rdata[23:16], icache_rdata[31:24]};
   assign rd_nxt   = rd_ptr + PW'(1);
   assign wr_nxt   = wr_ptr + PW'(1);
   assign head     = fifo_mem[rd_ptr];
   assign next_hw  = fifo_mem[rd_nxt];
   assign head_rvc = (head[1:0] != 2'b11);
   assign head_ok  = head_rvc ? (count >= CW'(1)) : (count >= CW'(2));

   assign icache_ren = !rst && (count <= CW'(FIFO_DEPTH - 2));
   assign accept     = icache_ren && !icache_stall && !redirect_valid && !pend;
   assign out_valid  = !rst && head_ok && !redirect_valid && !pend;
   assign pop        = out_valid && out_ready;
   assign push_n     = !accept ? 2'd0 : (drop_low ? 2'd1 : 2'd2);
   assign pop_n      = !pop ? 2'd0 : (head_rvc ? 2'd1 : 2'd2);
   assign out_is_rvc = !rst && head_rvc;

   always_comb begin
      out_inst = 32'h0;
      if (!rst) begin
         if (!head_rvc) out_inst = {next_hw, head};
`ifdef RVC_EXPAND_EN
         else           out_inst = expand_rvc(head);
`else
         else           out_inst = {16'h0000, head};
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         if (drop_low) begin
            fifo_mem[wr_ptr] <= hi_hw;
         end else begin
            fifo_mem[wr_ptr] <= lo_hw;
            fifo_mem[wr_nxt] <= hi_hw;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         icache_addr <= RESET_PC[31:2];
         out_pc      <= RESET_PC & 32'hFFFF_FFFE;
         drop_low    <= RESET_PC[1];
         pend        <= 1'b0;
      end else if (redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         out_pc <= redirect_pc & 32'hFFFF_FFFE;
         // during a stall the cache address must not move; remember the target instead
         if (icache_stall) begin
            pend      <= 1'b1;
            pend_addr <= redirect_pc[31:2];
            pend_drop <= redirect_pc[1];
         end else begin
            icache_addr <= redirect_pc[31:2];
            drop_low    <= redirect_pc[1];
            pend        <= 1'b0;
         end
      end else if (pend) begin
         if (!icache_stall) begin
            icache_addr <= pend_addr;
            drop_low    <= pend_drop;
            pend        <= 1'b0;
         end
      end else begin
         if (accept) begin
            wr_ptr      <= wr_ptr + PW'(push_n);
            drop_low    <= 1'b0;
            icache_addr <= icache_addr + 30'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(pop_n);
            out_pc <= out_pc + (head_rvc ? 32'd2 : 32'd4);
         end
         count <= count + CW'(push_n) - CW'(pop_n);
      end
   end
endmodule
